vote_button_conditioner: RTL and testbench
==========================================

VOTE_BUTTON_CONDITIONER -- requirements
Module: vote_button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized-stable cycles needed to accept a level change; legal range 2..255.
REQ-002 clock  input  1  single clock for all logic; rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mode  input  1  0 = voting, vote pulses enabled; 1 = result display, vote pulses suppressed.
REQ-005 button1..button4  input  1 each  raw asynchronous push-button levels, active-high.
REQ-006 vote1..vote4  output  1 each  registered single-cycle accepted-vote pulses; drive votingMachine button1..button4 directly.
REQ-007 collision  output  1  registered single-cycle pulse: a qualifying press was discarded.
REQ-008 busy  output  1  registered level, high while any channel is not IDLE.

Function
REQ-009 Each buttonN shall pass through a 2-flop synchronizer, reset to 0, before any other use.
REQ-010 Each channel shall have a 4-state FSM (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and an 8-bit stability counter.
REQ-011 IDLE: sync=1 -> PRESS_WAIT, counter=0; else stay.
REQ-012 PRESS_WAIT: sync=0 -> IDLE; sync=1 and counter=DEBOUNCE_CYCLES-1 -> HELD (channel qualifies); else counter+1.
REQ-013 HELD: sync=0 -> RELEASE_WAIT, counter=0; else stay; no pulse while held, however long.
REQ-014 RELEASE_WAIT: sync=1 -> HELD; sync=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-015 Counter shall never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-016 On qualification, voteN shall go high for exactly one cycle, the cycle after the PRESS_WAIT->HELD transition edge.
REQ-017 Press latency: button stable high from edge 0 -> voteN high during the cycle after edge 2+DEBOUNCE_CYCLES (6 at default).
REQ-018 A press stable for fewer than DEBOUNCE_CYCLES synchronized cycles shall produce no pulse.
REQ-019 Two or more channels qualifying on the same edge: no vote pulse, collision pulses once, all qualifying channels enter HELD.
REQ-020 At most one of vote1..vote4 shall be high in any cycle.
REQ-021 mode=1 on the qualifying edge: pulse suppressed, FSM still enters HELD, collision stays low.
REQ-022 mode changes shall not alter FSM state or counters.
REQ-023 busy = registered OR of (state != IDLE) over all channels.

Reset
REQ-024 Reset asserted: synchronizers 0, all FSMs IDLE, counters 0, vote1..4/collision/busy 0, immediately without a clock edge.
REQ-025 Reset asserted mid-debounce or mid-hold: in-progress press discarded, no pulse.
REQ-026 Button still held at reset release: treated as a new press; pulses after full REQ-017 latency.

Configuration
REQ-027 Macro VOTE_LOCKOUT_EN selects one-vote-per-release lockout.
REQ-028 VOTE_LOCKOUT_EN defined: after any vote pulse, a lock flag sets and clears only when all four channels are IDLE. A channel qualifying while locked enters HELD without pulse and collision pulses once.
REQ-029 VOTE_LOCKOUT_EN undefined: no lock flag; channels independent except for REQ-019.
REQ-030 REQ-001..REQ-026 shall hold unchanged in both builds.

Verification
REQ-031 Defaults, 10 ns clock, reset released at 10 ns; button1 high 50 ns -> vote1 one 10 ns pulse at REQ-017 latency, busy high until 4 cycles after synchronized release, no other outputs.
REQ-032 button2 pulses high 20 ns (2 cycles) three times, 30 ns apart -> no vote2 pulse, collision stays 0.
REQ-033 button3 and button4 rise on the same edge, held 100 ns -> vote3=vote4=0 throughout, collision single pulse at the REQ-017 cycle.
REQ-034 mode=1, button1 held 80 ns -> no vote pulses. Then mode=0, button1 released 60 ns, pressed again 50 ns -> exactly one vote1 pulse.
REQ-035 button2 held 200 ns with reset pulsed 10 ns at 40 ns -> exactly one vote2 pulse, 6 cycles after reset release; no pulse before reset.
REQ-036 VOTE_LOCKOUT_EN defined: button1 held, then button4 pressed 60 ns later while button1 still held -> vote1 pulse, no vote4, one collision pulse. Undefined: vote1 then vote4 pulses, collision 0.

Source files
------------

// File: rtl/vote_button_conditioner.sv
// Debounce and arbitrate four vote buttons into single-cycle vote pulses.
// Optional build macro VOTE_LOCKOUT_EN enables one-vote-per-release lockout.
module vote_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic mode,
    input  logic button1,
    input  logic button2,
    input  logic button3,
    input  logic button4,
    output logic vote1,
    output logic vote2,
    output logic vote3,
    output logic vote4,
    output logic collision,
    output logic busy
);

    typedef enum logic [1:0] {
        st_idle,
        st_press_wait,
        st_held,
        st_release_wait
    } state_e;

    localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sync1_q, sync2_q;
    state_e     state_q [4];
    state_e     state_d [4];
    logic [7:0] cnt_q   [4];
    logic [7:0] cnt_d   [4];
    logic [3:0] qual;
    logic       multi;
    logic       locked;
    logic [3:0] vote_d, vote_q;
    logic       coll_d, coll_q;
    logic       busy_d, busy_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {button4, button3, button2, button1};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        qual = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                st_idle: begin
                    if (sync2_q[i]) begin
                        state_d[i] = st_press_wait;
                        cnt_d[i]   = '0;
                    end
                end
                st_press_wait: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = st_idle;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = st_held;
                        qual[i]    = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                st_held: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = st_release_wait;
                        cnt_d[i]   = '0;
                    end
                end
                st_release_wait: begin
                    if (sync2_q[i]) begin
                        state_d[i] = st_held;
                    end else if (cnt_q[i] == CntMax) begin
                        state_d[i] = st_idle;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end
                default: begin
                    state_d[i] = st_idle;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

`ifdef VOTE_LOCKOUT_EN
    logic lock_q, lock_d;
    logic all_idle;

    always_comb begin
        all_idle = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (state_q[i] != st_idle) all_idle = 1'b0;
        end
        // Lock holds until every channel has fully returned to idle.
        lock_d = (lock_q && !all_idle) || (vote_d != 4'b0000);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        multi  = (qual & (qual - 4'd1)) != 4'b0000;
        vote_d = (!mode && !locked && !multi) ? qual : 4'b0000;
        coll_d = !mode && (qual != 4'b0000) && (multi || locked);
        busy_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (state_d[i] != st_idle) busy_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= st_idle;
                cnt_q[i]   <= '0;
            end
            vote_q <= '0;
            coll_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            vote_q <= vote_d;
            coll_q <= coll_d;
            busy_q <= busy_d;
        end
    end

    assign vote1     = vote_q[0];
    assign vote2     = vote_q[1];
    assign vote3     = vote_q[2];
    assign vote4     = vote_q[3];
    assign collision = coll_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vote_button_conditioner.sv
// Randomized bench for vote_button_conditioner against a run-length debounce model.
// Follows the DUT build: define VOTE_LOCKOUT_EN for both to test the lockout variant.
module tb_vote_button_conditioner;

    localparam int D = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mode = 1'b0;
    logic button1 = 1'b0, button2 = 1'b0, button3 = 1'b0, button4 = 1'b0;
    logic vote1, vote2, vote3, vote4, collision, busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_votes = 0;

    // Reference model state: two-sample delay line plus run lengths of the synchronized level.
    logic [3:0] h1 = '0, h2 = '0;
    int  run1 [4];
    int  run0 [4];
    bit  down [4];
    bit  lock = 1'b0;
    logic [3:0] exp_vote = '0;
    logic exp_coll = 1'b0;
    logic exp_busy = 1'b0;

    vote_button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .button1(button1), .button2(button2), .button3(button3), .button4(button4),
        .vote1(vote1), .vote2(vote2), .vote3(vote3), .vote4(vote4),
        .collision(collision), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] b, input logic m, input logic r);
        logic [3:0] s, q;
        int nq;
        bit all_idle, lck;
        if (r) begin
            h1 = '0; h2 = '0; lock = 1'b0;
            for (int i = 0; i < 4; i++) begin run1[i] = 0; run0[i] = 0; down[i] = 0; end
            exp_vote = '0; exp_coll = 1'b0; exp_busy = 1'b0;
            return;
        end
        s = h2; h2 = h1; h1 = b;
        all_idle = 1'b1;
        for (int i = 0; i < 4; i++) if (down[i] || run1[i] != 0) all_idle = 1'b0;
        q = '0;
        for (int i = 0; i < 4; i++) begin
            if (!down[i]) begin
                if (s[i]) begin
                    run1[i]++;
                    // Accept after D+1 consecutive high samples (entry sample plus D counts).
                    if (run1[i] == D + 1) begin
                        q[i] = 1'b1; down[i] = 1; run1[i] = 0; run0[i] = 0;
                    end
                end else run1[i] = 0;
            end else begin
                if (!s[i]) begin
                    run0[i]++;
                    if (run0[i] == D + 1) begin down[i] = 0; run0[i] = 0; end
                end else run0[i] = 0;
            end
        end
        nq = $countones(q);
`ifdef VOTE_LOCKOUT_EN
        lck = lock;
`else
        lck = 1'b0;
`endif
        exp_vote = (!m && !lck && nq == 1) ? q : 4'b0000;
        exp_coll = !m && nq > 0 && (nq > 1 || lck);
        lock = (lock && !all_idle) || (exp_vote != 0);
        if (exp_vote != 0) n_votes++;
        exp_busy = 1'b0;
        for (int i = 0; i < 4; i++) if (down[i] || run1[i] != 0) exp_busy = 1'b1;
    endtask

    // Called at a falling edge: drive, step the model at the rising edge, compare at the next fall.
    task automatic cycle(input logic [3:0] b, input logic m, input logic r);
        logic rose;
        rose = r && !reset;
        {button4, button3, button2, button1} = b;
        mode = m;
        reset = r;
        if (rose) begin
            #1;
            check("reset_immediate", {1'b0, busy, collision, vote4, vote3, vote2, vote1}, 8'h00);
        end
        @(posedge clock);
        model_step(b, m, r);
        @(negedge clock);
        cyc++;
        check("vote", {4'b0, vote4, vote3, vote2, vote1}, {4'b0, exp_vote});
        check("collision", {7'b0, collision}, {7'b0, exp_coll});
        check("busy", {7'b0, busy}, {7'b0, exp_busy});
        check("vote_onehot", {7'b0, ($countones({vote4, vote3, vote2, vote1}) <= 1)}, 8'h01);
    endtask

    task automatic repeat_cycle(input int n, input logic [3:0] b, input logic m, input logic r);
        for (int k = 0; k < n; k++) cycle(b, m, r);
    endtask

    initial begin
        logic [3:0] lvl;
        int tmr [4];
        logic m;
        int a, c;
        for (int i = 0; i < 4; i++) begin run1[i] = 0; run0[i] = 0; down[i] = 0; tmr[i] = 0; end
        @(negedge clock);
        check("reset_state", {1'b0, busy, collision, vote4, vote3, vote2, vote1}, 8'h00);
        reset = 1'b0;
        model_step(4'b0, 1'b0, 1'b1);

        // Directed scenarios
        repeat_cycle(5, 4'b0001, 1'b0, 1'b0);
        repeat_cycle(12, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            repeat_cycle(2, 4'b0010, 1'b0, 1'b0);
            repeat_cycle(3, 4'b0000, 1'b0, 1'b0);
        end
        repeat_cycle(8, 4'b0000, 1'b0, 1'b0);
        repeat_cycle(10, 4'b1100, 1'b0, 1'b0);
        repeat_cycle(12, 4'b0000, 1'b0, 1'b0);
        repeat_cycle(8, 4'b0001, 1'b1, 1'b0);
        repeat_cycle(6, 4'b0000, 1'b0, 1'b0);
        repeat_cycle(5, 4'b0001, 1'b0, 1'b0);
        repeat_cycle(12, 4'b0000, 1'b0, 1'b0);
        repeat_cycle(3, 4'b0010, 1'b0, 1'b0);
        repeat_cycle(1, 4'b0010, 1'b0, 1'b1);
        repeat_cycle(16, 4'b0010, 1'b0, 1'b0);
        repeat_cycle(12, 4'b0000, 1'b0, 1'b0);
        repeat_cycle(12, 4'b0001, 1'b0, 1'b0);
        repeat_cycle(8, 4'b1001, 1'b0, 1'b0);
        repeat_cycle(12, 4'b0000, 1'b0, 1'b0);

        // Randomized level runs: mostly long presses, some glitches, occasional paired rises
        lvl = '0;
        m = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (tmr[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    tmr[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(4, 14);
                end else tmr[i]--;
            end
            if ($urandom_range(0, 40) == 0) begin
                a = $urandom_range(0, 3);
                c = $urandom_range(0, 3);
                lvl[a] = 1'b1; lvl[c] = 1'b1;
                tmr[a] = 10;   tmr[c] = 10;
            end
            if ($urandom_range(0, 80) == 0) m = ~m;
            cycle(lvl, m, ($urandom_range(0, 300) == 0));
        end
        check("votes_seen", {7'b0, (n_votes > 0)}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
